wb_scratch_ram: RTL
===================

# wb_scratch_ram

Pipelined Wishbone B4 slave (responder) that terminates one of the data bus's 18 slave ports with a small word-addressed scratch RAM. Accepts single-beat reads and writes with byte selects, inserts a configurable number of wait states and drives stall while busy. Used as a bus-fabric test target and as general-purpose low-latency storage.

## Interface
- DATA_WIDTH, 32: data width in bits (8, 16, 32 or 64).
- ADDR_WIDTH, 32: width of wb_adr (word address).
- SELECT_WIDTH, DATA_WIDTH/8: byte-select width.
- DEPTH, 256: number of words; power of two, 2..4096.
- WAIT_STATES, 0: cycles inserted between acceptance and ack, 0..15.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_cyc  in  1  cycle valid.
- wb_stb  in  1  strobe.
- wb_we  in  1  1 = write.
- wb_adr  in  ADDR_WIDTH  word address.
- wb_sel  in  SELECT_WIDTH  byte enables.
- wb_dat_w  in  DATA_WIDTH  write data.
- wb_dat_r  out  DATA_WIDTH  read data, valid only with wb_ack.
- wb_ack  out  1  successful termination, one cycle per request.
- wb_err  out  1  error termination, one cycle per request.
- wb_stall  out  1  request not accepted this cycle.

## Operation
- Accept: wb_cyc & wb_stb & !wb_stall at a rising edge. Latch we, index = wb_adr[log2(DEPTH)-1:0], sel, dat_w.
- FSM states IDLE, WAIT, RESP:
  - IDLE: stall=0. On accept -> WAIT with counter = WAIT_STATES if WAIT_STATES>0, else -> RESP.
  - WAIT: stall=1; counter decrements each cycle; at 1 -> RESP.
  - RESP: ack (or err) high exactly one cycle. If WAIT_STATES==0, stall=0 and a new accept in RESP re-enters RESP (back-to-back, one transfer per cycle); else stall=1 and -> IDLE.
- Write: committed on the edge entering RESP; only bytes with sel=1 updated; sel=0 write still acks, no change.
- Read: wb_dat_r = mem[index] during the RESP cycle, 0 otherwise. sel ignored on reads.
- Abort: wb_cyc low in WAIT -> IDLE next edge, no ack, write not committed. wb_cyc low during RESP: ack still driven for that cycle (master ignores).
- Exactly one termination per accepted request; ack and err never simultaneous.
- RAM contents are not reset.

## Timing
- Reset (rst_n low, asynchronous, mid-operation included): state IDLE, counter 0, wb_ack=0, wb_err=0, wb_stall=0, wb_dat_r=0. In-flight request dropped, uncommitted write lost.
- Latency accept->ack: WAIT_STATES+1 cycles.
- Throughput: 1 per cycle at WAIT_STATES=0; 1 per WAIT_STATES+2 cycles otherwise.
- Outputs registered; no combinational path from inputs to wb_ack/wb_err/wb_dat_r. wb_stall is a function of state only.

## Configuration
- WB_SCRATCH_RAM_ERR_EN defined: requests with wb_adr >= DEPTH terminate with wb_err instead of wb_ack, same latency; no write, wb_dat_r=0.
- Undefined: wb_err tied 0; upper address bits ignored, addresses alias modulo DEPTH.

## Test plan
- Reset release, WAIT_STATES=0: write 0xDEADBEEF to adr 4 sel=0xF, read adr 4 -> ack 1 cycle after each accept, dat_r=0xDEADBEEF, stall never high.
- Byte enables: mem[7]=0x11223344, write 0xAABBCCDD sel=0x5 -> read returns 0x11BB33DD.
- WAIT_STATES=3: back-to-back stb -> first ack 4 cycles after accept, stall high 4 cycles, second request accepted on the ack cycle's following edge; exactly two acks.
- WAIT_STATES=3, write adr 2, drop wb_cyc 1 cycle after accept -> no ack; read adr 2 returns prior value.
- rst_n asserted in WAIT -> outputs go to reset values asynchronously; no ack after release.
- With WB_SCRATCH_RAM_ERR_EN, DEPTH=256: read adr 256 -> err, dat_r=0, no ack; without macro, write adr 256 then read adr 0 -> same data.

Source files
------------

// File: rtl/wb_scratch_ram.sv
// Pipelined Wishbone B4 slave terminating on a word-addressed scratch RAM with optional wait states.
// Define WB_SCRATCH_RAM_ERR_EN to answer addresses >= DEPTH with wb_err instead of aliasing them.
module wb_scratch_ram #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int DEPTH        = 256,
   parameter int WAIT_STATES  = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wb_cyc,
   input  logic                    wb_stb,
   input  logic                    wb_we,
   input  logic [ADDR_WIDTH-1:0]   wb_adr,
   input  logic [SELECT_WIDTH-1:0] wb_sel,
   input  logic [DATA_WIDTH-1:0]   wb_dat_w,
   output logic [DATA_WIDTH-1:0]   wb_dat_r,
   output logic                    wb_ack,
   output logic                    wb_err,
   output logic                    wb_stall
);
   // state | meaning
   // IDLE  | ready for a request, stall low
   // WAIT  | request held, counting wait states down, stall high
   // RESP  | ack/err presented for exactly one cycle
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int         IDX_W      = $clog2(DEPTH);
   localparam logic [3:0] WS         = 4'(WAIT_STATES);
   localparam logic       RESP_STALL = (WAIT_STATES != 0);

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    we_q, we_d;
   logic                    oob_q, oob_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [SELECT_WIDTH-1:0] sel_q, sel_d;
   logic [DATA_WIDTH-1:0]   dat_q, dat_d;
   logic                    ack_q, err_q;
   logic [DATA_WIDTH-1:0]   dat_r_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic stall, accept, adr_oob, resp_d, commit;
   logic unused_adr_hi;

`ifdef WB_SCRATCH_RAM_ERR_EN
   assign adr_oob = (wb_adr >> IDX_W) != '0;
`else
   assign adr_oob = 1'b0;
`endif
   assign unused_adr_hi = ^(wb_adr >> IDX_W);

   always_comb begin
      stall = 1'b0;
      case (state_q)
         IDLE:    stall = 1'b0;
         WAIT:    stall = 1'b1;
         RESP:    stall = RESP_STALL;
         default: stall = 1'b0;
      endcase
   end

   assign wb_stall = stall;
   assign accept   = wb_cyc & wb_stb & ~stall;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (WS != 4'd0) begin
                  state_d = WAIT;
                  cnt_d   = WS;
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            // dropping wb_cyc abandons the request; it never reaches RESP
            if (!wb_cyc) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == 4'd1) begin
               state_d = RESP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = accept ? RESP : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // with no wait states the request is used straight off the bus
   assign we_d   = accept ? wb_we                : we_q;
   assign oob_d  = accept ? adr_oob              : oob_q;
   assign idx_d  = accept ? wb_adr[IDX_W-1:0]    : idx_q;
   assign sel_d  = accept ? wb_sel               : sel_q;
   assign dat_d  = accept ? wb_dat_w             : dat_q;
   assign resp_d = (state_d == RESP);
   assign commit = resp_d & we_d & ~oob_d & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         oob_q   <= 1'b0;
         idx_q   <= '0;
         sel_q   <= '0;
         dat_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_r_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         oob_q   <= oob_d;
         idx_q   <= idx_d;
         sel_q   <= sel_d;
         dat_q   <= dat_d;
         ack_q   <= resp_d & ~oob_d;
         err_q   <= resp_d & oob_d;
         dat_r_q <= (resp_d & ~we_d & ~oob_d) ? mem[idx_d] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int b = 0; b < SELECT_WIDTH; b++) begin
            if (sel_d[b]) mem[idx_d][b*8 +: 8] <= dat_d[b*8 +: 8];
         end
      end
   end

   assign wb_ack   = ack_q;
   assign wb_err   = err_q;
   assign wb_dat_r = dat_r_q;
endmodule
